mem_port_arbiter: RTL

- Parametrised arbiter and sequencer for the runtime SRAM parallel port.
- Multiplexes NUM_CH requesters (boot loader, JTAG port, core, ...) onto one o_memAddr/o_memWr/o_memEn/data port.
- Supports fixed-priority or round-robin grant, configurable access length, per-channel enable mask and read-to-write bus turnaround.
- Drives the output-enable for the top-level Tristate array, which replaces the direct JTAG-to-SRAM wiring.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the SRAM parallel-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TURN   = 2'd1,
    ACCESS = 2'd2
  } arbState_e;

  // Wide enough for ACCESS_CYC-1 up to 14
  localparam int ACC_CNT_W = 4;

  function automatic int chIdxW(input int numCh);
    return (numCh > 1) ? $clog2(numCh) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational priority pick over a request vector, starting at a rotating offset.
// An offset of zero gives plain lowest-index-wins priority.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int IDX_W  = chIdxW(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDX_W-1:0]  i_offset,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_any
);

  // Walk the channels from the offset upward, wrapping, and keep the first hit
  always_comb begin
    logic [IDX_W:0]   chSum;
    logic [IDX_W-1:0] ch;
    logic             hit;
    o_gnt = {NUM_CH{1'b0}};
    o_idx = {IDX_W{1'b0}};
    o_any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      chSum = {1'b0, i_offset} + (IDX_W + 1)'(i);
      chSum = (chSum >= (IDX_W + 1)'(NUM_CH)) ? (chSum - (IDX_W + 1)'(NUM_CH)) : chSum;
      ch    = chSum[IDX_W-1:0];
      hit   = !o_any && i_req[ch];
      o_gnt[ch] = o_gnt[ch] | hit;
      o_idx = hit ? ch : o_idx;
      o_any = o_any | hit;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter and access sequencer multiplexing NUM_CH requesters onto the SRAM port,
// including read-to-write turnaround and the tristate drive enable.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int ACCESS_CYC = 2,
  parameter int RR_MODE    = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic [NUM_CH-1:0]          i_reqValid,
  input  logic [NUM_CH-1:0]          i_reqWr,
  input  logic [NUM_CH*ADDR_W-1:0]   i_reqAddr,
  input  logic [NUM_CH*DATA_W-1:0]   i_reqData,
  input  logic [NUM_CH-1:0]          i_chEn,
  output logic [NUM_CH-1:0]          o_reqGnt,
  output logic                       o_rspValid,
  output logic [$clog2(NUM_CH)-1:0]  o_rspCh,
  output logic [DATA_W-1:0]          o_rspData,
  output logic [ADDR_W-1:0]          o_memAddr,
  output logic                       o_memWr,
  output logic                       o_memEn,
  output logic [DATA_W-1:0]          o_memDataOut,
  output logic                       o_memDataOe,
  input  logic [DATA_W-1:0]          i_memDataIn
);

  localparam int CH_W = chIdxW(NUM_CH);
  localparam logic [ACC_CNT_W-1:0] CNT_LOAD = ACC_CNT_W'(ACCESS_CYC - 1);
  localparam logic [CH_W-1:0]      PTR_RST  = CH_W'(NUM_CH - 1);

  arbState_e            state_r, nextState_s;
  logic [ACC_CNT_W-1:0] cnt_r, cntNext_s;
  logic                 latWr_r, latWrNext_s;
  logic [ADDR_W-1:0]    latAddr_r, latAddrNext_s;
  logic [DATA_W-1:0]    latData_r, latDataNext_s;
  logic [CH_W-1:0]      latCh_r, latChNext_s;
  logic [CH_W-1:0]      rrPtr_r, rrPtrNext_s, arbOffset_s;
  logic                 lastWasRead_r, lastWasReadNext_s;

  logic [NUM_CH-1:0]    elig_s, winGnt_s;
  logic [CH_W-1:0]      winIdx_s;
  logic                 winAny_s, needTurn_s, launch_s, accDone_s;

  logic [NUM_CH-1:0]    gntNext_s;
  logic                 memEnNext_s, memWrNext_s;
  logic [ADDR_W-1:0]    memAddrNext_s;
  logic [DATA_W-1:0]    memDataNext_s, rspDataNext_s;
  logic [CH_W-1:0]      rspChNext_s;

  assign elig_s = i_reqValid & i_chEn;

  // Round-robin search begins just past the last winner; fixed mode always starts at 0
  assign arbOffset_s = (RR_MODE == 0)      ? {CH_W{1'b0}} :
                       (rrPtr_r == PTR_RST) ? {CH_W{1'b0}} : (rrPtr_r + CH_W'(1));

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (CH_W)
  ) u_pick (
    .i_req    (elig_s),
    .i_offset (arbOffset_s),
    .o_gnt    (winGnt_s),
    .o_idx    (winIdx_s),
    .o_any    (winAny_s)
  );

  // Next-state, access counter and request latch selection
  always_comb begin
    nextState_s = state_r;
    cntNext_s   = cnt_r;
    launch_s    = 1'b0;
    accDone_s   = 1'b0;
    needTurn_s  = i_reqWr[winIdx_s] & lastWasRead_r;
    case (state_r)
      IDLE: begin
        if (winAny_s) begin
          launch_s    = 1'b1;
          nextState_s = needTurn_s ? TURN : ACCESS;
          cntNext_s   = CNT_LOAD;
        end else begin
          nextState_s = IDLE;
        end
      end
      TURN: begin
        nextState_s = ACCESS;
        cntNext_s   = CNT_LOAD;
      end
      ACCESS: begin
        if (cnt_r == {ACC_CNT_W{1'b0}}) begin
          accDone_s   = 1'b1;
          nextState_s = IDLE;
        end else begin
          cntNext_s = cnt_r - ACC_CNT_W'(1);
        end
      end
      default: begin
        nextState_s = IDLE;
        cntNext_s   = {ACC_CNT_W{1'b0}};
      end
    endcase
    latWrNext_s       = launch_s ? i_reqWr[winIdx_s] : latWr_r;
    latAddrNext_s     = launch_s ? i_reqAddr[winIdx_s*ADDR_W +: ADDR_W] : latAddr_r;
    latDataNext_s     = launch_s ? i_reqData[winIdx_s*DATA_W +: DATA_W] : latData_r;
    latChNext_s       = launch_s ? winIdx_s : latCh_r;
    rrPtrNext_s       = launch_s ? winIdx_s : rrPtr_r;
    lastWasReadNext_s = accDone_s ? ~latWr_r : lastWasRead_r;
  end

  // Output values for the coming cycle, derived from the state being entered
  always_comb begin
    memEnNext_s   = (nextState_s == ACCESS);
    memWrNext_s   = memEnNext_s & latWrNext_s;
    memAddrNext_s = memEnNext_s ? latAddrNext_s : o_memAddr;
    memDataNext_s = memWrNext_s ? latDataNext_s : {DATA_W{1'b0}};
    if (memEnNext_s && (state_r != ACCESS)) begin
      gntNext_s = {{(NUM_CH-1){1'b0}}, 1'b1} << latChNext_s;
    end else begin
      gntNext_s = {NUM_CH{1'b0}};
    end
    rspChNext_s   = accDone_s ? latCh_r : {CH_W{1'b0}};
    rspDataNext_s = (accDone_s && !latWr_r) ? i_memDataIn : o_rspData;
  end

  // State, counter, latched request and arbitration history
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r       <= IDLE;
      cnt_r         <= {ACC_CNT_W{1'b0}};
      latWr_r       <= 1'b0;
      latAddr_r     <= {ADDR_W{1'b0}};
      latData_r     <= {DATA_W{1'b0}};
      latCh_r       <= {CH_W{1'b0}};
      rrPtr_r       <= PTR_RST;
      lastWasRead_r <= 1'b0;
    end else begin
      state_r       <= nextState_s;
      cnt_r         <= cntNext_s;
      latWr_r       <= latWrNext_s;
      latAddr_r     <= latAddrNext_s;
      latData_r     <= latDataNext_s;
      latCh_r       <= latChNext_s;
      rrPtr_r       <= rrPtrNext_s;
      lastWasRead_r <= lastWasReadNext_s;
    end
  end

  // Registered port outputs
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_reqGnt     <= {NUM_CH{1'b0}};
      o_rspValid   <= 1'b0;
      o_rspCh      <= {CH_W{1'b0}};
      o_rspData    <= {DATA_W{1'b0}};
      o_memAddr    <= {ADDR_W{1'b0}};
      o_memWr      <= 1'b0;
      o_memEn      <= 1'b0;
      o_memDataOut <= {DATA_W{1'b0}};
      o_memDataOe  <= 1'b0;
    end else begin
      o_reqGnt     <= gntNext_s;
      o_rspValid   <= accDone_s;
      o_rspCh      <= rspChNext_s;
      o_rspData    <= rspDataNext_s;
      o_memAddr    <= memAddrNext_s;
      o_memWr      <= memWrNext_s;
      o_memEn      <= memEnNext_s;
      o_memDataOut <= memDataNext_s;
      o_memDataOe  <= memWrNext_s;
    end
  end

endmodule
